// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle for sync_fifo_fwft: producer side, consumer side, status and flush.
interface sync_fifo_fwft_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 256
);
    localparam int unsigned LB_FIFO_DEPTH = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LB_FIFO_DEPTH:0] count;
    logic                   almost_full;
    logic                   almost_empty;
    logic [LB_FIFO_DEPTH:0] max_count;
    logic                   clear;

    // Producer/consumer environment around the FIFO.
    modport master (
        output in_data, in_valid, out_ready, clear,
        input  in_ready, out_data, out_valid, count, almost_full, almost_empty, max_count
    );

    // The FIFO itself.
    modport slave (
        input  in_data, in_valid, out_ready, clear,
        output in_ready, out_data, out_valid, count, almost_full, almost_empty, max_count
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: dual-port RAM, one RAM read stage and a
// registered output word. Capacity FIFO_DEPTH words counted across all three places.
// Latency from push into an empty FIFO to out_valid is two edges; the read stage
// prefetches so back-to-back pops see no bubble.
module sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 256,
    parameter int unsigned LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
    parameter int unsigned AF_THRESH     = FIFO_DEPTH - 4,
    parameter int unsigned AE_THRESH     = 4
) (
    input logic              clk,
    input logic              rstn,
    sync_fifo_fwft_if.slave  bus
);
    localparam int unsigned CW = LB_FIFO_DEPTH + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AfCnt    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeCnt    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] r_wr_ptr;
    logic [LB_FIFO_DEPTH-1:0] r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic [CW-1:0]            r_max_count;
    logic                     r_rd_valid;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic                     r_almost_full;
    logic                     r_almost_empty;

    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_push;
    logic                     w_pop;
    logic [CW-1:0]            w_ram_cnt;
    logic                     w_rd_take;
    logic                     w_rd_load;
    logic [CW-1:0]            w_count_d;
    logic [CW-1:0]            w_max_d;

    // Handshakes, pipeline advance conditions and next count.
    always_comb begin
        w_in_ready  = rstn & ~bus.clear & (r_count < DepthCnt);
        w_out_valid = r_out_valid & ~bus.clear;
        w_push      = bus.in_valid & w_in_ready;
        w_pop       = w_out_valid & bus.out_ready;
        // Words still sitting in RAM, not yet moved into the read stage.
        w_ram_cnt   = r_count - CW'(r_rd_valid) - CW'(r_out_valid);
        // Read stage moves into the output register when that is empty or being popped.
        w_rd_take   = r_rd_valid & (~r_out_valid | w_pop);
        // RAM read only of words written at an earlier edge, so no write/read collision.
        w_rd_load   = ~bus.clear & (w_ram_cnt != '0) & (~r_rd_valid | w_rd_take);
        w_count_d   = r_count;
        if (bus.clear) begin
            w_count_d = '0;
        end else if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CW'(1);
        end
        w_max_d = r_max_count;
        if (bus.clear) begin
            w_max_d = '0;
        end else if (w_count_d > r_max_count) begin
            w_max_d = w_count_d;
        end
    end

    // RAM write port and prefetch read into the read stage; storage is never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
        if (w_rd_load) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers, valid flags, output word, count and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_max_count    <= '0;
            r_rd_valid     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_count        <= w_count_d;
            r_max_count    <= w_max_d;
            r_almost_full  <= (w_count_d >= AfCnt);
            r_almost_empty <= (w_count_d <= AeCnt);
            if (bus.clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_rd_valid  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_load) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_rd_load) begin
                    r_rd_valid <= 1'b1;
                end else if (w_rd_take) begin
                    r_rd_valid <= 1'b0;
                end
                if (w_rd_take) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_rd_data;
                end else if (w_pop) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.count        = r_count;
    assign bus.max_count    = r_max_count;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft at depth 8: a negedge monitor keeps a scoreboard of pushed
// words and compares every popped word; scenario tasks check status and timing inline.
module tb_sync_fifo_fwft;
    logic clk;
    logic rstn;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;
    int n_checks;
    int n_pass;

    sync_fifo_fwft_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) bus ();

    sync_fifo_fwft #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: record accepted words, compare each popped word against the oldest.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_pop: got %h, required nothing (queue empty)", bus.out_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if (bus.out_data !== mon_exp)
                        $display("FAIL sb_data: got %h, required %h", bus.out_data, mon_exp);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && bus.count !== 4'd0; c++) tick();
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL drain_timeout: count %0d, required 0", bus.count);
        else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.count !== 4'd0) $display("FAIL rst_count: got %0d, required 0", bus.count); else n_pass++;
        n_checks++; if (bus.almost_empty !== 1'b1) $display("FAIL rst_ae: got %b, required 1", bus.almost_empty); else n_pass++;
        n_checks++; if (bus.almost_full !== 1'b0) $display("FAIL rst_af: got %b, required 0", bus.almost_full); else n_pass++;
        n_checks++; if (bus.max_count !== 4'd0) $display("FAIL rst_max: got %0d, required 0", bus.max_count); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rst_out_data: got %h, required 00", bus.out_data); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_first_word();
        bus.in_data  = 8'h11;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.count !== 4'd1) $display("FAIL fw_count: got %0d, required 1", bus.count); else n_pass++;
        n_checks++; if (bus.almost_empty !== 1'b1) $display("FAIL fw_ae: got %b, required 1", bus.almost_empty); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fw_lat_t: got %b, required 0", bus.out_valid); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fw_lat_t1: got %b, required 0", bus.out_valid); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fw_lat_t2: got %b, required 1", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h11) $display("FAIL fw_data: got %h, required 11", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (bus.count !== 4'd0) $display("FAIL fw_pop_count: got %0d, required 0", bus.count); else n_pass++;
    endtask

    task automatic test_fill();
        logic e_af;
        logic e_ae;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_data  = 8'(i);
            bus.in_valid = 1'b1;
            tick();
            e_af = (i + 1 >= 6);
            e_ae = (i + 1 <= 1);
            n_checks++; if (bus.count !== 4'(i + 1)) $display("FAIL fill_count: got %0d, required %0d", bus.count, i + 1); else n_pass++;
            n_checks++; if (bus.almost_full !== e_af) $display("FAIL fill_af: got %b, required %b at count %0d", bus.almost_full, e_af, i + 1); else n_pass++;
            n_checks++; if (bus.almost_empty !== e_ae) $display("FAIL fill_ae: got %b, required %b at count %0d", bus.almost_empty, e_ae, i + 1); else n_pass++;
        end
        bus.in_data = 8'h99;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.count !== 4'd8) $display("FAIL full_count: got %0d, required 8", bus.count); else n_pass++;
        n_checks++; if (bus.max_count !== 4'd8) $display("FAIL full_max: got %0d, required 8", bus.max_count); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL full_head: got %h, required 00", bus.out_data); else n_pass++;
    endtask

    task automatic test_drain_from_full();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h20;
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL pop_at_full_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_bubble: out_valid %b, required 1 at pop %0d", bus.out_valid, k); else n_pass++;
            tick();
            bus.in_data = 8'(8'h21 + k);
            if (k == 0) begin
                n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL after_full_in_ready: got %b, required 1", bus.in_ready); else n_pass++;
                n_checks++; if (bus.count !== 4'd7) $display("FAIL after_full_count: got %0d, required 7", bus.count); else n_pass++;
            end
        end
        drain();
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL empty_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.almost_empty !== 1'b1) $display("FAIL empty_ae: got %b, required 1", bus.almost_empty); else n_pass++;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = 8'(8'h40 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.count !== 4'd3) $display("FAIL stream_pre_count: got %0d, required 3", bus.count); else n_pass++;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.in_data = 8'(8'h43 + k);
            #1;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stream_valid: got %b, required 1 at word %0d", bus.out_valid, k); else n_pass++;
            tick();
            n_checks++; if (bus.count !== 4'd3) $display("FAIL stream_count: got %0d, required 3 at word %0d", bus.count, k); else n_pass++;
        end
        drain();
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 8'(8'h60 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.count !== 4'd5) $display("FAIL clr_pre_count: got %0d, required 5", bus.count); else n_pass++;
        bus.clear     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hEE;
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL clr_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clr_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        tick();
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        n_checks++; if (bus.count !== 4'd0) $display("FAIL clr_count: got %0d, required 0", bus.count); else n_pass++;
        n_checks++; if (bus.max_count !== 4'd0) $display("FAIL clr_max: got %0d, required 0", bus.max_count); else n_pass++;
        n_checks++; if (bus.almost_empty !== 1'b1) $display("FAIL clr_ae: got %b, required 1", bus.almost_empty); else n_pass++;
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 8 && bus.out_valid !== 1'b1; c++) tick();
        n_checks++; if (bus.out_data !== 8'h5A || bus.out_valid !== 1'b1) $display("FAIL clr_new_data: got %h valid %b, required 5A valid 1", bus.out_data, bus.out_valid); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_data  = 8'(8'h70 + i);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_data = 8'h74;
        n_checks++; if (bus.count !== 4'd4) $display("FAIL rmid_pre_count: got %0d, required 4", bus.count); else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (bus.count !== 4'd0) $display("FAIL rmid_count: got %0d, required 0", bus.count); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rmid_out_data: got %h, required 00", bus.out_data); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.max_count !== 4'd0) $display("FAIL rmid_max: got %0d, required 0", bus.max_count); else n_pass++;
        n_checks++; if (bus.almost_empty !== 1'b1) $display("FAIL rmid_ae: got %b, required 1", bus.almost_empty); else n_pass++;
        sb.delete();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        rstn = 1'b1;
        tick();
        bus.in_data  = 8'h7A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'h7B;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 8 && bus.out_valid !== 1'b1; c++) tick();
        n_checks++; if (bus.out_data !== 8'h7A || bus.out_valid !== 1'b1) $display("FAIL rmid_first: got %h valid %b, required 7A valid 1", bus.out_data, bus.out_valid); else n_pass++;
        drain();
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rstn          = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        test_reset();
        test_first_word();
        test_fill();
        test_drain_from_full();
        test_stream();
        test_clear();
        test_reset_mid();
        tick();
        n_checks++; if (sb.size() != 0) $display("FAIL sb_leftover: %0d words, required 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
